// File: rtl/fetch_unit.sv
// Instruction fetch stage with a DEPTH-entry show-ahead prefetch queue.
// Issues word-aligned fetches, buffers responses and flushes on redirect.
module fetch_unit #(
    parameter int              XLEN     = 32,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req_valid,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_req_ready,
    input  logic            imem_resp_valid,
    input  logic [XLEN-1:0] imem_resp_data,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            instr_valid,
    output logic [XLEN-1:0] instr,
    output logic [XLEN-1:0] instr_pc,
    output logic [XLEN-1:0] instr_pc_plus4,
    input  logic            instr_ready
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    localparam logic [1:0] FETCH = 2'd0;
    localparam logic [1:0] WAIT  = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;

    logic [1:0]      state;
    logic [XLEN-1:0] fetch_pc;
    logic [XLEN-1:0] req_pc;
    logic [XLEN-1:0] q_instr [DEPTH];
    logic [XLEN-1:0] q_pc    [DEPTH];
    logic [AW-1:0]   rd_ptr;
    logic [AW-1:0]   wr_ptr;
    logic [AW:0]     count;
    logic            req_fire;
    logic            enq;
    logic            deq;
    logic            pending;

    assign imem_req_valid = rst && (state == FETCH) && (count < FULL);
    assign imem_req_addr  = fetch_pc;
    assign req_fire       = imem_req_valid && imem_req_ready;

    assign instr_valid    = rst && (count != '0);
    assign instr          = instr_valid ? q_instr[rd_ptr] : '0;
    assign instr_pc       = instr_valid ? q_pc[rd_ptr] : '0;
    assign instr_pc_plus4 = instr_pc + XLEN'(4);

    assign enq = rst && (state == WAIT) && imem_resp_valid && !redirect_valid;
    assign deq = instr_valid && instr_ready && !redirect_valid;

    // A response arriving in the redirect cycle closes the outstanding request.
    assign pending = ((state == WAIT || state == DRAIN) && !imem_resp_valid)
                   || req_fire;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= FETCH;
            fetch_pc <= RESET_PC;
            req_pc   <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
        end else if (redirect_valid) begin
            state    <= pending ? DRAIN : FETCH;
            fetch_pc <= {redirect_pc[XLEN-1:2], 2'b00};
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
        end else begin
            case (state)
                FETCH: begin
                    if (req_fire) begin
                        state    <= WAIT;
                        req_pc   <= fetch_pc;
                        fetch_pc <= fetch_pc + XLEN'(4);
                    end
                end
                WAIT: begin
                    if (imem_resp_valid) state <= FETCH;
                end
                DRAIN: begin
                    if (imem_resp_valid) state <= FETCH;
                end
                default: state <= FETCH;
            endcase
            if (enq) wr_ptr <= wr_ptr + 1'b1;
            if (deq) rd_ptr <= rd_ptr + 1'b1;
            unique case (1'b1)
                (enq && !deq): count <= count + 1'b1;
                (deq && !enq): count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (enq) begin
            q_instr[wr_ptr] <= imem_resp_data;
            q_pc[wr_ptr]    <= req_pc;
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: memory responder plus in-order PC-stream model.
// Second instance exercises PC wrap from RESET_PC = 32'hFFFF_FFFC.
module tb_fetch_unit;
    localparam logic [31:0] B_RESET = 32'hFFFF_FFFC;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b0;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready = 1'b0;
    logic        imem_resp_valid = 1'b0;
    logic [31:0] imem_resp_data = '0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic [31:0] instr_pc_plus4;
    logic        instr_ready = 1'b0;

    logic        b_req_valid;
    logic [31:0] b_req_addr;
    logic        b_req_ready = 1'b1;
    logic        b_resp_valid = 1'b0;
    logic [31:0] b_resp_data = '0;
    logic        b_redirect_valid = 1'b0;
    logic [31:0] b_redirect_pc = '0;
    logic        b_instr_valid;
    logic [31:0] b_instr;
    logic [31:0] b_instr_pc;
    logic [31:0] b_instr_pc_plus4;
    logic        b_instr_ready = 1'b1;

    fetch_unit #(.XLEN(32), .DEPTH(4), .RESET_PC(32'h0)) dut (
        .clk(clk), .rst(rst),
        .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr),
        .imem_req_ready(imem_req_ready),
        .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc),
        .instr_pc_plus4(instr_pc_plus4), .instr_ready(instr_ready)
    );

    fetch_unit #(.XLEN(32), .DEPTH(4), .RESET_PC(B_RESET)) dut_b (
        .clk(clk), .rst(rst),
        .imem_req_valid(b_req_valid), .imem_req_addr(b_req_addr),
        .imem_req_ready(b_req_ready),
        .imem_resp_valid(b_resp_valid), .imem_resp_data(b_resp_data),
        .redirect_valid(b_redirect_valid), .redirect_pc(b_redirect_pc),
        .instr_valid(b_instr_valid), .instr(b_instr), .instr_pc(b_instr_pc),
        .instr_pc_plus4(b_instr_pc_plus4), .instr_ready(b_instr_ready)
    );

    int nchk = 0;
    int nerr = 0;

    function automatic logic [31:0] memf(input logic [31:0] a);
        return ~a ^ 32'h1357_9BDF;
    endfunction

    typedef struct {
        logic [31:0] addr;
        int          dly;
    } pend_t;

    pend_t       pend[$];
    logic [31:0] acc_q[$];
    logic [31:0] b_acc[$];
    int          ready_mode = 0;
    int          lat_lo = 1;
    int          lat_hi = 1;
    logic        b_pend = 1'b0;
    logic [31:0] b_pend_addr = '0;

    // Memory for dut: in-order responses after lat_lo..lat_hi cycles.
    always begin
        pend_t e;
        @(negedge clk);
        #1;
        imem_resp_valid = 1'b0;
        if (!rst) begin
            pend.delete();
        end else if (pend.size() > 0) begin
            if (pend[0].dly == 0) begin
                imem_resp_valid = 1'b1;
                imem_resp_data  = memf(pend[0].addr);
                pend.delete(0);
            end else begin
                pend[0].dly = pend[0].dly - 1;
            end
        end
        case (ready_mode)
            0:       imem_req_ready = 1'b1;
            1:       imem_req_ready = ($urandom_range(0, 1) == 1);
            default: imem_req_ready = 1'b0;
        endcase
        #1;
        if (rst && imem_req_valid && imem_req_ready) begin
            e.addr = imem_req_addr;
            e.dly  = int'($urandom_range(lat_lo, lat_hi)) - 1;
            pend.push_back(e);
            acc_q.push_back(imem_req_addr);
        end
    end

    // Memory for dut_b: always ready, 1-cycle response.
    always begin
        @(negedge clk);
        #1;
        b_resp_valid = rst && b_pend;
        b_resp_data  = memf(b_pend_addr);
        b_pend       = 1'b0;
        #1;
        if (rst && b_req_valid && b_req_ready) begin
            b_pend      = 1'b1;
            b_pend_addr = b_req_addr;
            b_acc.push_back(b_req_addr);
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        redirect_valid = 1'b0;
        instr_ready = 1'b0;
        repeat (2) @(negedge clk);
        acc_q.delete();
        b_acc.delete();
        rst = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #3;
        nchk++;
        if (imem_req_valid !== 1'b0 || instr_valid !== 1'b0) begin
            nerr++;
            $display("FAIL rst_valids got req=%b iv=%b want 0 0", imem_req_valid, instr_valid);
        end
        nchk++;
        if (instr !== 32'h0 || instr_pc !== 32'h0) begin
            nerr++;
            $display("FAIL rst_outs got instr=%h pc=%h want 0 0", instr, instr_pc);
        end
        nchk++;
        if (b_req_valid !== 1'b0) begin
            nerr++;
            $display("FAIL rst_b_req got %b want 0", b_req_valid);
        end
        @(negedge clk);
        rst = 1'b1;
        #3;
        nchk++;
        if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0) begin
            nerr++;
            $display("FAIL rst_first_req got v=%b a=%h want 1 0", imem_req_valid, imem_req_addr);
        end
        nchk++;
        if (instr_valid !== 1'b0) begin
            nerr++;
            $display("FAIL rst_iv_after got %b want 0", instr_valid);
        end
        nchk++;
        if (b_req_addr !== B_RESET) begin
            nerr++;
            $display("FAIL rst_b_addr got %h want %h", b_req_addr, B_RESET);
        end
    endtask

    task automatic test_stream();
        logic [31:0] exp_pc = 32'h0;
        int got = 0;
        int last = -1;
        ready_mode = 0;
        lat_lo = 1;
        lat_hi = 1;
        do_reset();
        instr_ready = 1'b1;
        for (int c = 0; c < 24; c++) begin
            #3;
            if (instr_valid && instr_ready) begin
                nchk++;
                if (instr_pc !== exp_pc || instr !== memf(exp_pc)
                    || instr_pc_plus4 !== exp_pc + 32'd4) begin
                    nerr++;
                    $display("FAIL stream_instr got pc=%h i=%h p4=%h want pc=%h i=%h p4=%h",
                             instr_pc, instr, instr_pc_plus4, exp_pc, memf(exp_pc), exp_pc + 32'd4);
                end
                if (last >= 0) begin
                    nchk++;
                    if (c - last != 2) begin
                        nerr++;
                        $display("FAIL stream_gap got %0d want 2", c - last);
                    end
                end
                last = c;
                exp_pc = exp_pc + 32'd4;
                got++;
            end
            @(negedge clk);
        end
        nchk++;
        if (got != 11) begin
            nerr++;
            $display("FAIL stream_count got %0d want 11", got);
        end
    endtask

    task automatic test_full();
        logic [31:0] exp_pc = 32'h0;
        int got = 0;
        int c = 0;
        ready_mode = 0;
        lat_lo = 1;
        lat_hi = 1;
        do_reset();
        repeat (14) @(negedge clk);
        #3;
        nchk++;
        if (acc_q.size() != 4 || imem_req_valid !== 1'b0 || instr_valid !== 1'b1) begin
            nerr++;
            $display("FAIL full_state got acc=%0d req=%b iv=%b want 4 0 1",
                     acc_q.size(), imem_req_valid, instr_valid);
        end
        for (int i = 0; i < 4 && i < acc_q.size(); i++) begin
            nchk++;
            if (acc_q[i] !== 32'(i * 4)) begin
                nerr++;
                $display("FAIL full_addr%0d got %h want %h", i, acc_q[i], 32'(i * 4));
            end
        end
        @(negedge clk);
        instr_ready = 1'b1;
        for (int k = 0; k < 20 && got < 4; k++) begin
            #3;
            if (instr_valid) begin
                nchk++;
                if (instr_pc !== exp_pc || instr !== memf(exp_pc)) begin
                    nerr++;
                    $display("FAIL full_drain got pc=%h i=%h want pc=%h i=%h",
                             instr_pc, instr, exp_pc, memf(exp_pc));
                end
                exp_pc = exp_pc + 32'd4;
                got++;
            end
            @(negedge clk);
        end
        nchk++;
        if (got != 4) begin
            nerr++;
            $display("FAIL full_drain_count got %0d want 4", got);
        end
        #3;
        while (acc_q.size() < 5 && c < 10) begin
            @(negedge clk);
            #3;
            c++;
        end
        nchk++;
        if (acc_q.size() < 5 || acc_q[4] !== 32'h10) begin
            nerr++;
            $display("FAIL full_resume got n=%0d a=%h want a=00000010",
                     acc_q.size(), acc_q.size() >= 5 ? acc_q[4] : 32'hx);
        end
        instr_ready = 1'b0;
    endtask

    task automatic test_redirect_wait();
        int c = 0;
        ready_mode = 0;
        lat_lo = 3;
        lat_hi = 3;
        do_reset();
        #3;
        while (acc_q.size() < 3 && c < 40) begin
            @(negedge clk);
            #3;
            c++;
        end
        nchk++;
        if (acc_q.size() != 3 || acc_q[2] !== 32'h8) begin
            nerr++;
            $display("FAIL rw_issue got n=%0d want 3 with addr 8", acc_q.size());
        end
        @(negedge clk);
        redirect_valid = 1'b1;
        redirect_pc = 32'h100;
        #3;
        nchk++;
        if (instr_valid !== 1'b1 || imem_req_valid !== 1'b0) begin
            nerr++;
            $display("FAIL rw_before got iv=%b req=%b want 1 0", instr_valid, imem_req_valid);
        end
        @(negedge clk);
        redirect_valid = 1'b0;
        instr_ready = 1'b1;
        #3;
        nchk++;
        if (instr_valid !== 1'b0 || imem_req_valid !== 1'b0) begin
            nerr++;
            $display("FAIL rw_flush got iv=%b req=%b want 0 0", instr_valid, imem_req_valid);
        end
        c = 0;
        while (!instr_valid && c < 30) begin
            @(negedge clk);
            #3;
            c++;
        end
        nchk++;
        if (acc_q.size() < 4 || acc_q[3] !== 32'h100) begin
            nerr++;
            $display("FAIL rw_next_addr got n=%0d want addr 100 at index 3", acc_q.size());
        end
        nchk++;
        if (instr_valid !== 1'b1 || instr_pc !== 32'h100 || instr !== memf(32'h100)) begin
            nerr++;
            $display("FAIL rw_first got iv=%b pc=%h i=%h want 1 100 %h",
                     instr_valid, instr_pc, instr, memf(32'h100));
        end
        instr_ready = 1'b0;
    endtask

    task automatic test_redirect_full();
        int c = 0;
        ready_mode = 0;
        lat_lo = 1;
        lat_hi = 1;
        do_reset();
        repeat (14) @(negedge clk);
        #3;
        nchk++;
        if (acc_q.size() != 4 || instr_valid !== 1'b1 || imem_req_valid !== 1'b0) begin
            nerr++;
            $display("FAIL rf_full got acc=%0d iv=%b req=%b want 4 1 0",
                     acc_q.size(), instr_valid, imem_req_valid);
        end
        @(negedge clk);
        redirect_valid = 1'b1;
        redirect_pc = 32'h203;
        instr_ready = 1'b1;
        @(negedge clk);
        redirect_valid = 1'b0;
        instr_ready = 1'b0;
        #3;
        nchk++;
        if (instr_valid !== 1'b0) begin
            nerr++;
            $display("FAIL rf_empty got iv=%b want 0", instr_valid);
        end
        nchk++;
        if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h200) begin
            nerr++;
            $display("FAIL rf_addr got v=%b a=%h want 1 200", imem_req_valid, imem_req_addr);
        end
        @(negedge clk);
        instr_ready = 1'b1;
        #3;
        while (!instr_valid && c < 20) begin
            @(negedge clk);
            #3;
            c++;
        end
        nchk++;
        if (instr_valid !== 1'b1 || instr_pc !== 32'h200) begin
            nerr++;
            $display("FAIL rf_first got iv=%b pc=%h want 1 200", instr_valid, instr_pc);
        end
        instr_ready = 1'b0;
    endtask

    task automatic test_stall();
        ready_mode = 2;
        lat_lo = 1;
        lat_hi = 1;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            #3;
            nchk++;
            if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0 || acc_q.size() != 0) begin
                nerr++;
                $display("FAIL stall_hold%0d got v=%b a=%h n=%0d want 1 0 0",
                         i, imem_req_valid, imem_req_addr, acc_q.size());
            end
            @(negedge clk);
        end
        ready_mode = 0;
        #3;
        nchk++;
        if (acc_q.size() != 1 || acc_q[0] !== 32'h0) begin
            nerr++;
            $display("FAIL stall_accept got n=%0d want 1 accept of addr 0", acc_q.size());
        end
        @(negedge clk);
        #3;
        nchk++;
        if (imem_req_valid !== 1'b0) begin
            nerr++;
            $display("FAIL stall_wait got %b want 0", imem_req_valid);
        end
    endtask

    task automatic test_wrap();
        logic seen = 1'b0;
        do_reset();
        for (int c = 0; c < 12; c++) begin
            #3;
            if (b_instr_valid && !seen) begin
                seen = 1'b1;
                nchk++;
                if (b_instr_pc !== B_RESET || b_instr_pc_plus4 !== 32'h0
                    || b_instr !== memf(B_RESET)) begin
                    nerr++;
                    $display("FAIL wrap_first got pc=%h p4=%h i=%h want %h 0 %h",
                             b_instr_pc, b_instr_pc_plus4, b_instr, B_RESET, memf(B_RESET));
                end
            end
            @(negedge clk);
        end
        nchk++;
        if (!seen) begin
            nerr++;
            $display("FAIL wrap_seen got 0 want 1");
        end
        nchk++;
        if (b_acc.size() < 2 || b_acc[0] !== B_RESET || b_acc[1] !== 32'h0) begin
            nerr++;
            $display("FAIL wrap_addrs got n=%0d want FFFFFFFC then 0", b_acc.size());
        end
    endtask

    task automatic test_random();
        logic [31:0] exp_pc = 32'h0;
        int got = 0;
        ready_mode = 1;
        lat_lo = 1;
        lat_hi = 3;
        do_reset();
        for (int c = 0; c < 800; c++) begin
            redirect_valid = ($urandom_range(0, 19) == 0);
            redirect_pc = $urandom;
            instr_ready = ($urandom_range(0, 1) == 1);
            #3;
            if (instr_valid) begin
                nchk++;
                if (instr_pc_plus4 !== instr_pc + 32'd4) begin
                    nerr++;
                    $display("FAIL rand_plus4 got %h want %h", instr_pc_plus4, instr_pc + 32'd4);
                end
            end
            if (instr_valid && instr_ready && !redirect_valid) begin
                nchk++;
                if (instr_pc !== exp_pc || instr !== memf(exp_pc)) begin
                    nerr++;
                    $display("FAIL rand_instr got pc=%h i=%h want pc=%h i=%h",
                             instr_pc, instr, exp_pc, memf(exp_pc));
                end
                exp_pc = exp_pc + 32'd4;
                got++;
            end
            if (redirect_valid) exp_pc = {redirect_pc[31:2], 2'b00};
            @(negedge clk);
        end
        redirect_valid = 1'b0;
        instr_ready = 1'b0;
        nchk++;
        if (got < 20) begin
            nerr++;
            $display("FAIL rand_progress got %0d want at least 20", got);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_stream();
        test_full();
        test_redirect_wait();
        test_redirect_full();
        test_stall();
        test_wrap();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end
endmodule
